// File: rtl/fifo_demo_pkg.sv
// Shared state and operation encodings for the FIFO button sequencer.
package fifo_demo_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      OP_WR = 1'b0,
      OP_RD = 1'b1
   } op_t;

endpackage

// File: rtl/btn_rise_detect.sv
// Registers the previous button level and flags a 0->1 transition.
module btn_rise_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic rise_o
);

   logic prev_q;

   // Resetting to 1 keeps a button held through reset from looking like a press.
   always_ff @(posedge clk) begin
      if (rst) prev_q <= RESET_VAL;
      else     prev_q <= btn_i;
   end

   assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/fifo_button_sequencer.sv
// Converts write/read button levels into single-cycle FIFO push/pop strobes with
// press arbitration, hold-to-repeat and a saturating count of blocked attempts.
module fifo_button_sequencer
   import fifo_demo_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int HOLD_CYC   = 50_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   parameter int REJ_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_btn,
   input  logic              rd_btn,
   input  logic [DATA_W-1:0] din_sw,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_wr_data,
   output logic              fifo_rd_en,
   output logic              reject_pulse,
   output logic [REJ_W-1:0]  reject_cnt,
   output logic              busy
);

   localparam int TIMER_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
   localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYC - 1);
   localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYC - 1);

   state_t              state_q, state_d;
   op_t                 op_q, op_d;
   op_t                 grant_q, grant_d;
   logic                rep_q, rep_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [DATA_W-1:0]   wrData_q, wrData_d;
   logic [REJ_W-1:0]    rejectCnt_q, rejectCnt_d;

   logic                wrRise, rdRise;
   logic                opBtn;
   logic [TIMER_W-1:0]  timerLast;

   btn_rise_detect #(.RESET_VAL(1'b1)) u_wrRise (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (wr_btn),
      .rise_o (wrRise)
   );

   btn_rise_detect #(.RESET_VAL(1'b1)) u_rdRise (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (rd_btn),
      .rise_o (rdRise)
   );

   assign opBtn     = (op_q == OP_WR) ? wr_btn : rd_btn;
   assign timerLast = rep_q ? REPEAT_LAST : HOLD_LAST;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_WR;
         grant_q     <= OP_WR;
         rep_q       <= 1'b0;
         timer_q     <= '0;
         wrData_q    <= '0;
         rejectCnt_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         grant_q     <= grant_d;
         rep_q       <= rep_d;
         timer_q     <= timer_d;
         wrData_q    <= wrData_d;
         rejectCnt_q <= rejectCnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      grant_d      = grant_q;
      rep_d        = rep_q;
      timer_d      = timer_q;
      wrData_d     = wrData_q;
      rejectCnt_d  = rejectCnt_q;
      fifo_wr_en   = 1'b0;
      fifo_rd_en   = 1'b0;
      reject_pulse = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Simultaneous presses alternate between write and read.
            if (wrRise && rdRise) begin
               op_d    = grant_q;
               grant_d = (grant_q == OP_WR) ? OP_RD : OP_WR;
               state_d = S_ISSUE;
            end else if (wrRise) begin
               op_d    = OP_WR;
               state_d = S_ISSUE;
            end else if (rdRise) begin
               op_d    = OP_RD;
               state_d = S_ISSUE;
            end
            if (state_d == S_ISSUE) begin
               rep_d = 1'b0;
               if (op_d == OP_WR) wrData_d = din_sw;
            end
         end

         S_ISSUE: begin
            if (op_q == OP_WR) begin
               fifo_wr_en   = ~fifo_full;
               reject_pulse = fifo_full;
            end else begin
               fifo_rd_en   = ~fifo_empty;
               reject_pulse = fifo_empty;
            end
            if (reject_pulse && (rejectCnt_q != '1)) rejectCnt_d = rejectCnt_q + 1'b1;
            state_d = S_WAIT;
            timer_d = '0;
         end

         S_WAIT: begin
            // Release takes priority; the timer stops at its last value so it never wraps.
            if (!opBtn) begin
               state_d = S_IDLE;
               rep_d   = 1'b0;
            end else if (timer_q == timerLast) begin
               state_d = S_ISSUE;
               rep_d   = 1'b1;
               if (op_q == OP_WR) wrData_d = din_sw;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign fifo_wr_data = wrData_q;
   assign reject_cnt   = rejectCnt_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_button_sequencer.sv
// Scoreboard bench: each press queues its expected strobe/reject with data and cycle.
module tb_fifo_button_sequencer;

   localparam int KIND_WR  = 0;
   localparam int KIND_RD  = 1;
   localparam int KIND_REJ = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_btn, rd_btn;
   logic [7:0] din_sw;
   logic       fifo_full, fifo_empty;
   logic       fifo_wr_en, fifo_rd_en, reject_pulse, busy;
   logic [7:0] fifo_wr_data;
   logic [7:0] reject_cnt;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   expCnt = 0;
   exp_t expQ[$];

   int   obsKind;
   exp_t front;

   fifo_button_sequencer #(
      .DATA_W     (8),
      .HOLD_CYC   (8),
      .REPEAT_CYC (4),
      .REJ_W      (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_btn       (wr_btn),
      .rd_btn       (rd_btn),
      .din_sw       (din_sw),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .fifo_rd_en   (fifo_rd_en),
      .reject_pulse (reject_pulse),
      .reject_cnt   (reject_cnt),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every strobe or reject must match the oldest queued expectation.
   always begin
      @(posedge clk);
      #1;
      checks++;
      if ($countones({fifo_wr_en, fifo_rd_en, reject_pulse}) > 1) begin
         errors++;
         $display("[TB] FAIL exclusive wr_en=%0b rd_en=%0b rej=%0b required at most one high",
                  fifo_wr_en, fifo_rd_en, reject_pulse);
      end
      if (fifo_wr_en || fifo_rd_en || reject_pulse) begin
         obsKind = fifo_wr_en ? KIND_WR : (fifo_rd_en ? KIND_RD : KIND_REJ);
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event kind=%0d cyc=%0d required none", obsKind, cyc);
         end else begin
            front = expQ.pop_front();
            if (obsKind !== front.kind || cyc !== front.cyc ||
                (front.kind == KIND_WR && fifo_wr_data !== front.data)) begin
               errors++;
               $display("[TB] FAIL event kind=%0d cyc=%0d data=%h required kind=%0d cyc=%0d data=%h",
                        obsKind, cyc, fifo_wr_data, front.kind, front.cyc, front.data);
            end
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expectEvent(input int kind, input logic [7:0] data, input int when);
      exp_t e;
      e.kind = kind;
      e.data = data;
      e.cyc  = when;
      expQ.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_btn = 1'b0; rd_btn = 1'b0;
      din_sw = 8'h00; fifo_full = 1'b0; fifo_empty = 1'b0;
      waitCycles(3);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en got=%b want=0", fifo_wr_en); end
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en got=%b want=0", fifo_rd_en); end
      checks++; if (reject_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_reject_pulse got=%b want=0", reject_pulse); end
      checks++; if (reject_cnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_reject_cnt got=%h want=00", reject_cnt); end
      checks++; if (fifo_wr_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_data got=%h want=00", fifo_wr_data); end
      rst = 1'b0;
      expCnt = 0;
      waitCycles(2);
   endtask

   task automatic test_single_write();
      din_sw = 8'hA5;
      wr_btn = 1'b1;
      expectEvent(KIND_WR, 8'hA5, cyc + 1);
      waitCycles(3);
      wr_btn = 1'b0;
      din_sw = 8'h00;
      waitCycles(3);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy got=%b want=0", busy); end
      checks++; if (fifo_wr_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_wr_data_hold got=%h want=a5", fifo_wr_data); end
      checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL single_pending got=%0d want=0", expQ.size()); end
   endtask

   task automatic test_auto_repeat();
      logic [7:0] rptData [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      int         rptOff  [6] = '{1, 10, 15, 20, 25, 30};
      int         c0;
      c0 = cyc;
      din_sw = rptData[0];
      wr_btn = 1'b1;
      expectEvent(KIND_WR, rptData[0], c0 + rptOff[0]);
      for (int step = 1; step <= 30; step++) begin
         @(negedge clk);
         for (int k = 0; k < 5; k++) begin
            if (step == rptOff[k]) begin
               din_sw = rptData[k+1];
               expectEvent(KIND_WR, rptData[k+1], c0 + rptOff[k+1]);
            end
         end
      end
      wr_btn = 1'b0;
      waitCycles(4);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL repeat_busy got=%b want=0", busy); end
      checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL repeat_pending got=%0d want=0", expQ.size()); end
   endtask

   task automatic test_reject();
      fifo_empty = 1'b1;
      rd_btn = 1'b1;
      expectEvent(KIND_REJ, 8'h00, cyc + 1);
      expCnt = expCnt + 1;
      waitCycles(2);
      rd_btn = 1'b0;
      waitCycles(3);
      checks++; if (reject_cnt !== 8'(expCnt)) begin errors++; $display("[TB] FAIL reject_empty_cnt got=%h want=%h", reject_cnt, 8'(expCnt)); end
      fifo_empty = 1'b0;
      fifo_full  = 1'b1;
      din_sw = 8'hC7;
      wr_btn = 1'b1;
      expectEvent(KIND_REJ, 8'h00, cyc + 1);
      expCnt = expCnt + 1;
      waitCycles(2);
      wr_btn = 1'b0;
      waitCycles(3);
      checks++; if (reject_cnt !== 8'(expCnt)) begin errors++; $display("[TB] FAIL reject_full_cnt got=%h want=%h", reject_cnt, 8'(expCnt)); end
      fifo_full = 1'b0;
      rd_btn = 1'b1;
      expectEvent(KIND_RD, 8'h00, cyc + 1);
      waitCycles(2);
      rd_btn = 1'b0;
      waitCycles(3);
      checks++; if (reject_cnt !== 8'(expCnt)) begin errors++; $display("[TB] FAIL read_ok_cnt got=%h want=%h", reject_cnt, 8'(expCnt)); end
      checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL reject_pending got=%0d want=0", expQ.size()); end
   endtask

   task automatic test_saturation();
      fifo_empty = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rd_btn = 1'b1;
         expectEvent(KIND_REJ, 8'h00, cyc + 1);
         waitCycles(1);
         rd_btn = 1'b0;
         waitCycles(2);
         if (expCnt < 255) expCnt = expCnt + 1;
         checks++;
         if (reject_cnt !== 8'(expCnt)) begin
            errors++;
            $display("[TB] FAIL saturate_cnt iter=%0d got=%h want=%h", i, reject_cnt, 8'(expCnt));
         end
      end
      fifo_empty = 1'b0;
      checks++; if (reject_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL saturate_final got=%h want=ff", reject_cnt); end
      checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL saturate_pending got=%0d want=0", expQ.size()); end
   endtask

   task automatic test_back_to_back();
      rst = 1'b1;
      waitCycles(2);
      rst = 1'b0;
      expCnt = 0;
      checks++; if (reject_cnt !== 8'h00) begin errors++; $display("[TB] FAIL arb_reset_cnt got=%h want=00", reject_cnt); end
      waitCycles(2);
      din_sw = 8'h3C;
      wr_btn = 1'b1; rd_btn = 1'b1;
      expectEvent(KIND_WR, 8'h3C, cyc + 1);
      waitCycles(2);
      wr_btn = 1'b0; rd_btn = 1'b0;
      waitCycles(3);
      din_sw = 8'hC3;
      wr_btn = 1'b1; rd_btn = 1'b1;
      expectEvent(KIND_RD, 8'h00, cyc + 1);
      waitCycles(2);
      wr_btn = 1'b0; rd_btn = 1'b0;
      waitCycles(3);
      checks++; if (fifo_wr_data !== 8'h3C) begin errors++; $display("[TB] FAIL arb_wr_data_hold got=%h want=3c", fifo_wr_data); end
      din_sw = 8'h5A;
      wr_btn = 1'b1; rd_btn = 1'b1;
      expectEvent(KIND_WR, 8'h5A, cyc + 1);
      waitCycles(2);
      wr_btn = 1'b0; rd_btn = 1'b0;
      waitCycles(3);
      checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL arb_pending got=%0d want=0", expQ.size()); end
   endtask

   task automatic test_reset_in_wait();
      din_sw = 8'h77;
      wr_btn = 1'b1;
      expectEvent(KIND_WR, 8'h77, cyc + 1);
      waitCycles(3);
      rst = 1'b1;
      waitCycles(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL abort_wr_en got=%b want=0", fifo_wr_en); end
      rst = 1'b0;
      expCnt = 0;
      waitCycles(12);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL held_after_reset_busy got=%b want=0", busy); end
      checks++; if (fifo_wr_data !== 8'h00) begin errors++; $display("[TB] FAIL held_after_reset_data got=%h want=00", fifo_wr_data); end
      checks++; if (reject_cnt !== 8'(expCnt)) begin errors++; $display("[TB] FAIL held_after_reset_cnt got=%h want=00", reject_cnt); end
      wr_btn = 1'b0;
      waitCycles(2);
      din_sw = 8'h88;
      wr_btn = 1'b1;
      expectEvent(KIND_WR, 8'h88, cyc + 1);
      waitCycles(2);
      wr_btn = 1'b0;
      waitCycles(3);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL repress_busy got=%b want=0", busy); end
      checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL repress_pending got=%0d want=0", expQ.size()); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_auto_repeat();
      test_reject();
      test_saturation();
      test_back_to_back();
      test_reset_in_wait();
      waitCycles(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
